// File: rtl/music_player.sv
// music_player: ROM-driven square-wave tune player with per-step timing and optional looping
module music_player #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int STEP_CYCLES = 12_500_000,
    parameter int SONG_LEN    = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play,
    input  logic       loop,
    input  logic [7:0] note,
    output logic [7:0] address,
    output logic       buzzer,
    output logic       playing,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, LOAD, PLAY} state_t;

    localparam real SEMI = 1.0594630943592953;

    // Half-period in clocks for note code n; 0 marks a rest code.
    function automatic int div_of(input int n);
        real f;
        f = 440.0;
        if (n < 1 || n > 48) return 0;
        for (int i = 21; i < n; i++) f = f * SEMI;
        for (int i = n; i < 21; i++) f = f / SEMI;
        return $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
    endfunction

    localparam int         DW   = $clog2(div_of(1) + 1);
    localparam int         SW   = $clog2(STEP_CYCLES + 1);
    localparam logic [7:0] LAST = 8'(SONG_LEN - 1);

    logic [DW-1:0] w_div [64];
    for (genvar g = 0; g < 64; g++) begin : g_div
        assign w_div[g] = DW'(div_of(g));
    end

    state_t        r_state, w_state;
    logic [7:0]    r_addr, w_addr, r_cur, w_cur;
    logic [SW-1:0] r_step, w_step;
    logic [DW-1:0] r_tone, w_tone, w_d;
    logic          r_buzz, w_buzz, r_done, w_done, r_playing, w_pitched;

    assign w_pitched = (r_cur != 8'd0) && (r_cur <= 8'd48);
    assign w_d       = w_div[r_cur[5:0]];

    // Next-state, step timing, note latching and tone generation.
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_step  = r_step + SW'(1);
        w_tone  = r_tone;
        w_buzz  = r_buzz;
        w_cur   = r_cur;
        w_done  = 1'b0;
        if (!w_pitched) begin
            w_tone = '0;
            w_buzz = 1'b0;
        end else if (r_tone == w_d - DW'(1)) begin
            w_tone = '0;
            w_buzz = ~r_buzz;
        end else begin
            w_tone = r_tone + DW'(1);
        end
        case (r_state)
            IDLE: begin
                w_state = play ? ADDR : IDLE;
                w_step  = '0;
            end
            ADDR: w_state = WAIT;
            WAIT: w_state = LOAD;
            LOAD: begin
                w_state = PLAY;
                w_cur   = note;
                if (note != r_cur) begin
                    w_tone = '0;
                    w_buzz = 1'b0;
                end
            end
            PLAY: begin
                if (r_step == SW'(STEP_CYCLES - 1)) begin
                    w_step = '0;
                    if (r_addr < LAST) begin
                        w_addr  = r_addr + 8'd1;
                        w_state = ADDR;
                    end else if (loop) begin
                        w_addr  = 8'd0;
                        w_state = ADDR;
                    end else begin
                        w_done  = 1'b1;
                        w_state = IDLE;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
        if (r_state != IDLE && !play) begin
            w_state = IDLE;
            w_done  = 1'b0;
        end
        if (w_state == IDLE) begin
            w_addr = 8'd0;
            w_step = '0;
            w_tone = '0;
            w_buzz = 1'b0;
            w_cur  = 8'd0;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= 8'd0;
            r_step    <= '0;
            r_tone    <= '0;
            r_buzz    <= 1'b0;
            r_cur     <= 8'd0;
            r_done    <= 1'b0;
            r_playing <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_addr    <= w_addr;
            r_step    <= w_step;
            r_tone    <= w_tone;
            r_buzz    <= w_buzz;
            r_cur     <= w_cur;
            r_done    <= w_done;
            r_playing <= (w_state != IDLE);
        end
    end

    assign address = r_addr;
    assign buzzer  = r_buzz;
    assign playing = r_playing;
    assign done    = r_done;
endmodule
